// File: rtl/burst_ram_arbiter_if.sv
// burst_ram_arbiter_if
//   Bundles one BurstRAM-style command/data port. The same bundle is used
//   for each requester (m0/m1) and for the RAM side (br), so signal names
//   mirror the usual mN_* / br_* wiring with the prefix given by the
//   instance name.
//
//   Signals:
//     cmd           0 = read, 1 = write
//     cmd_en        one-cycle request pulse
//     addr          burst address
//     wr_data       write beat
//     data_mask     write byte mask (one bit per byte of wr_data)
//     rd_data       read beat
//     rd_data_valid read beat valid
//     busy          request pending or in flight
//     wr_beat       current wr_data/data_mask consumed this cycle
//
//   Modports:
//     master  the side that issues commands (a requester, or the arbiter
//             when it drives the RAM)
//     slave   the side that accepts commands (the arbiter towards a
//             requester, or the RAM)
interface burst_ram_arbiter_if #(
    parameter int RAM_DEPTH_BITWIDTH      = 8,
    parameter int RAM_BURST_DATA_BITWIDTH = 64
);
    localparam int MASK_W = RAM_BURST_DATA_BITWIDTH / 8;

    logic                               cmd;
    logic                               cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]      addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] wr_data;
    logic [MASK_W-1:0]                  data_mask;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] rd_data;
    logic                               rd_data_valid;
    logic                               busy;
    logic                               wr_beat;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, busy, wr_beat
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, busy, wr_beat
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter
//   Shares one BurstRAM between two requesters. Each requester gets a
//   one-deep pending slot; a round-robin arbiter picks a slot, issues one
//   command cycle to the RAM and then follows the burst (counting read
//   beats, or timing write beats) before returning to idle.
//
//   Ports:
//     clk   single clock
//     rst   asynchronous, active-high reset
//     m0    requester 0 (slave modport: the arbiter accepts its commands)
//     m1    requester 1 (slave modport)
//     br    RAM side (master modport: the arbiter drives the RAM);
//           br.wr_beat is not used by the arbiter
module burst_ram_arbiter #(
    parameter int RAM_DEPTH_BITWIDTH      = 8,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic clk,
    input  logic rst,
    burst_ram_arbiter_if.slave  m0,
    burst_ram_arbiter_if.slave  m1,
    burst_ram_arbiter_if.master br
);
    localparam int MASK_W = RAM_BURST_DATA_BITWIDTH / 8;
    localparam int CNT_W  = $clog2(RAM_BURST_DATA_COUNT) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        READ,
        WRITE
    } state_t;

    state_t                        r_state;
    logic [1:0]                    r_pendValid;
    logic [1:0]                    r_pendCmd;
    logic [RAM_DEPTH_BITWIDTH-1:0] r_pendAddr0;
    logic [RAM_DEPTH_BITWIDTH-1:0] r_pendAddr1;
    logic                          r_owner;
    logic                          r_lastGrant;
    logic [CNT_W-1:0]              r_beatCnt;
    logic                          r_brCmdEn;
    logic                          r_brCmd;
    logic [RAM_DEPTH_BITWIDTH-1:0] r_brAddr;

    logic w_busy0;
    logic w_busy1;
    logic w_accept0;
    logic w_accept1;
    logic w_grant;
    logic w_wrActive;
    logic w_rdActive;

    // A port is busy while its slot holds a request or while it owns the
    // transaction; a busy port's cmd_en is dropped, which also guarantees a
    // newly accepted request never lands in the slot being granted.
    assign w_busy0   = r_pendValid[0] | ((r_state != IDLE) & ~r_owner);
    assign w_busy1   = r_pendValid[1] | ((r_state != IDLE) &  r_owner);
    assign w_accept0 = m0.cmd_en & ~w_busy0;
    assign w_accept1 = m1.cmd_en & ~w_busy1;

    // Round robin: on a tie the port that did not win last time is chosen.
    assign w_grant = (&r_pendValid) ? ~r_lastGrant : r_pendValid[1];

    // Write beat 0 coincides with the ISSUE cycle; r_brCmd holds the owner's
    // command for the whole transaction.
    assign w_wrActive = ((r_state == ISSUE) & r_brCmd) | (r_state == WRITE);
    assign w_rdActive = (r_state == READ);

    // Single state machine: request capture, arbitration, command issue and
    // burst tracking all live here so every RAM-facing control is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pendValid <= 2'b00;
            r_pendCmd   <= 2'b00;
            r_pendAddr0 <= '0;
            r_pendAddr1 <= '0;
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_beatCnt   <= '0;
            r_brCmdEn   <= 1'b0;
            r_brCmd     <= 1'b0;
            r_brAddr    <= '0;
        end else begin
            if (w_accept0) begin
                r_pendValid[0] <= 1'b1;
                r_pendCmd[0]   <= m0.cmd;
                r_pendAddr0    <= m0.addr;
            end
            if (w_accept1) begin
                r_pendValid[1] <= 1'b1;
                r_pendCmd[1]   <= m1.cmd;
                r_pendAddr1    <= m1.addr;
            end

            case (r_state)
                IDLE: begin
                    if ((|r_pendValid) && !br.busy) begin
                        r_state              <= ISSUE;
                        r_owner              <= w_grant;
                        r_lastGrant          <= w_grant;
                        r_pendValid[w_grant] <= 1'b0;
                        r_brCmdEn            <= 1'b1;
                        r_brCmd              <= w_grant ? r_pendCmd[1] : r_pendCmd[0];
                        r_brAddr             <= w_grant ? r_pendAddr1 : r_pendAddr0;
                    end
                end

                ISSUE: begin
                    r_brCmdEn <= 1'b0;
                    if (r_brCmd) begin
                        // The ISSUE cycle already carried beat 0.
                        r_state   <= WRITE;
                        r_beatCnt <= CNT_W'(1);
                    end else begin
                        r_state   <= READ;
                        r_beatCnt <= '0;
                    end
                end

                READ: begin
                    if (br.rd_data_valid) begin
                        if (r_beatCnt == LAST_BEAT) begin
                            r_state   <= IDLE;
                            r_beatCnt <= '0;
                        end else begin
                            r_beatCnt <= r_beatCnt + CNT_W'(1);
                        end
                    end
                end

                WRITE: begin
                    if (r_beatCnt == LAST_BEAT) begin
                        r_state   <= IDLE;
                        r_beatCnt <= '0;
                    end else begin
                        r_beatCnt <= r_beatCnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign br.cmd_en    = r_brCmdEn;
    assign br.cmd       = r_brCmd;
    assign br.addr      = r_brAddr;
    assign br.wr_data   = w_wrActive ? (r_owner ? m1.wr_data : m0.wr_data)
                                     : {RAM_BURST_DATA_BITWIDTH{1'b0}};
    assign br.data_mask = w_wrActive ? (r_owner ? m1.data_mask : m0.data_mask)
                                     : {MASK_W{1'b0}};

    assign m0.busy          = w_busy0;
    assign m1.busy          = w_busy1;
    assign m0.wr_beat       = w_wrActive & ~r_owner;
    assign m1.wr_beat       = w_wrActive &  r_owner;
    assign m0.rd_data       = br.rd_data;
    assign m1.rd_data       = br.rd_data;
    // Valid beats outside READ (stray or late RAM output) are never forwarded.
    assign m0.rd_data_valid = br.rd_data_valid & w_rdActive & ~r_owner;
    assign m1.rd_data_valid = br.rd_data_valid & w_rdActive &  r_owner;
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter
//   Scoreboard bench for burst_ram_arbiter. Requests push the expected RAM
//   command, read beats and write beats into queues; a negedge monitor pops
//   and compares them as the arbiter produces them. A small RAM model
//   answers reads with an address/beat pattern and a one-cycle bubble.
module tb_burst_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int N  = 4;
    localparam int MW = DW / 8;

    typedef struct {
        int            port;
        logic          cmd;
        logic [AW-1:0] addr;
    } issue_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } wbeat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    issue_t        expIssue[$];
    wbeat_t        expWr[$];
    logic [DW-1:0] expRd0[$];
    logic [DW-1:0] expRd1[$];
    int            issueLog[$];
    int            endLog[$];

    logic [DW-1:0]        wrBuf0[N];
    logic [DW-1:0]        wrBuf1[N];
    logic [$clog2(N)-1:0] wrIdx0;
    logic [$clog2(N)-1:0] wrIdx1;

    logic          brBusy = 1'b0;
    logic          strayValid = 1'b0;
    logic          rValid;
    logic [DW-1:0] rData;
    logic [AW-1:0] rAddr;
    int            rLeft;
    int            rBeat;
    int            rWait;

    burst_ram_arbiter_if #(.RAM_DEPTH_BITWIDTH(AW), .RAM_BURST_DATA_BITWIDTH(DW)) m0If ();
    burst_ram_arbiter_if #(.RAM_DEPTH_BITWIDTH(AW), .RAM_BURST_DATA_BITWIDTH(DW)) m1If ();
    burst_ram_arbiter_if #(.RAM_DEPTH_BITWIDTH(AW), .RAM_BURST_DATA_BITWIDTH(DW)) brIf ();

    burst_ram_arbiter #(
        .RAM_DEPTH_BITWIDTH(AW),
        .RAM_BURST_DATA_BITWIDTH(DW),
        .RAM_BURST_DATA_COUNT(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m0(m0If),
        .m1(m1If),
        .br(brIf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rdPattern(input logic [AW-1:0] a, input int b);
        return {8'hC5, a, 32'h0, 16'(b)};
    endfunction

    // Requesters present the beat selected by how many wr_beat strobes they
    // have seen; a full burst wraps the index back to zero.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wrIdx0 <= '0;
            wrIdx1 <= '0;
        end else begin
            if (m0If.wr_beat) wrIdx0 <= wrIdx0 + 1'b1;
            if (m1If.wr_beat) wrIdx1 <= wrIdx1 + 1'b1;
        end
    end

    assign m0If.wr_data = wrBuf0[wrIdx0];
    assign m1If.wr_data = wrBuf1[wrIdx1];

    // RAM model: one idle cycle after the command, then N beats with a
    // single-cycle bubble after the second beat.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rValid <= 1'b0;
            rData  <= '0;
            rAddr  <= '0;
            rLeft  <= 0;
            rBeat  <= 0;
            rWait  <= 0;
        end else begin
            rValid <= 1'b0;
            if (brIf.cmd_en && !brIf.cmd) begin
                rLeft <= N;
                rBeat <= 0;
                rWait <= 1;
                rAddr <= brIf.addr;
            end else if (rLeft > 0) begin
                if (rWait > 0) begin
                    rWait <= rWait - 1;
                end else begin
                    rValid <= 1'b1;
                    rData  <= rdPattern(rAddr, rBeat);
                    rBeat  <= rBeat + 1;
                    rLeft  <= rLeft - 1;
                    rWait  <= (rBeat == 1) ? 1 : 0;
                end
            end
        end
    end

    assign brIf.rd_data_valid = rValid | strayValid;
    assign brIf.rd_data       = rValid ? rData : 64'hDEAD_BEEF_0BAD_F00D;
    assign brIf.busy          = brBusy;
    assign brIf.wr_beat       = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one request onto a port and, if it should be accepted, records
    // everything the arbiter is expected to produce for it.
    task automatic applyStimulus(input int port, input logic cmd, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] base, input logic [MW-1:0] mask,
                                 input bit expectAccept);
        if (port == 0) begin
            m0If.cmd    = cmd;
            m0If.addr   = addr;
            m0If.cmd_en = 1'b1;
            if (cmd) begin
                for (int i = 0; i < N; i++) wrBuf0[i] = base + DW'(i);
                m0If.data_mask = mask;
            end
        end else begin
            m1If.cmd    = cmd;
            m1If.addr   = addr;
            m1If.cmd_en = 1'b1;
            if (cmd) begin
                for (int i = 0; i < N; i++) wrBuf1[i] = base + DW'(i);
                m1If.data_mask = mask;
            end
        end
        if (expectAccept) begin
            expIssue.push_back('{port: port, cmd: cmd, addr: addr});
            for (int i = 0; i < N; i++) begin
                if (cmd) expWr.push_back('{data: base + DW'(i), mask: mask});
                else if (port == 0) expRd0.push_back(rdPattern(addr, i));
                else expRd1.push_back(rdPattern(addr, i));
            end
        end
    endtask

    task automatic startCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic releaseEnables();
        m0If.cmd_en = 1'b0;
        m1If.cmd_en = 1'b0;
    endtask

    task automatic waitIdle();
        int k = 0;
        while (k < 300 && !(m0If.busy == 1'b0 && m1If.busy == 1'b0 && expIssue.size() == 0 &&
                            expRd0.size() == 0 && expRd1.size() == 0 && expWr.size() == 0)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) checkOutput("idleTimeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard as the arbiter issues commands, forwards
    // read beats and consumes write beats; also checks busy drops one cycle
    // after the last read beat.
    initial begin : monitor
        issue_t        e;
        wbeat_t        w;
        logic [DW-1:0] d;
        logic          prevCmdEn = 1'b0;
        int            wrLeft = 0;
        int            wrPort = 0;
        int            rdCnt0 = 0;
        int            rdCnt1 = 0;
        bit            fallArm0 = 1'b0;
        bit            fallArm1 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                expIssue.delete();
                expRd0.delete();
                expRd1.delete();
                expWr.delete();
                prevCmdEn = 1'b0;
                wrLeft    = 0;
                rdCnt0    = 0;
                rdCnt1    = 0;
                fallArm0  = 1'b0;
                fallArm1  = 1'b0;
            end else begin
                if (fallArm0) checkOutput("m0BusyFall", m0If.busy, 0);
                if (fallArm1) checkOutput("m1BusyFall", m1If.busy, 0);
                fallArm0 = 1'b0;
                fallArm1 = 1'b0;

                if (brIf.cmd_en) begin
                    checkOutput("cmdEnPulse", prevCmdEn, 0);
                    if (expIssue.size() == 0) begin
                        checkOutput("issueUnexpected", {brIf.cmd, brIf.addr}, 0);
                    end else begin
                        e = expIssue.pop_front();
                        checkOutput("issueCmd", brIf.cmd, e.cmd);
                        checkOutput("issueAddr", brIf.addr, e.addr);
                        issueLog.push_back(cyc);
                        if (e.cmd) begin
                            wrLeft = N;
                            wrPort = e.port;
                        end
                    end
                end
                prevCmdEn = brIf.cmd_en;

                if (wrLeft > 0) begin
                    checkOutput("wrBeatOwner", (wrPort == 0) ? m0If.wr_beat : m1If.wr_beat, 1);
                    checkOutput("wrBeatOther", (wrPort == 0) ? m1If.wr_beat : m0If.wr_beat, 0);
                    if (expWr.size() == 0) begin
                        checkOutput("wrUnexpected", brIf.wr_data, 0);
                    end else begin
                        w = expWr.pop_front();
                        checkOutput("wrData", brIf.wr_data, w.data);
                        checkOutput("wrMask", brIf.data_mask, w.mask);
                    end
                    wrLeft--;
                    if (wrLeft == 0) endLog.push_back(cyc);
                end else begin
                    checkOutput("wrBeatIdle", {m1If.wr_beat, m0If.wr_beat}, 0);
                    checkOutput("wrDataIdle", brIf.wr_data, 0);
                    checkOutput("wrMaskIdle", brIf.data_mask, 0);
                end

                if (m0If.rd_data_valid || m1If.rd_data_valid)
                    checkOutput("validExclusive", m0If.rd_data_valid & m1If.rd_data_valid, 0);

                if (m0If.rd_data_valid) begin
                    if (expRd0.size() == 0) begin
                        checkOutput("m0RdUnexpected", m0If.rd_data, 0);
                    end else begin
                        d = expRd0.pop_front();
                        checkOutput("m0RdData", m0If.rd_data, d);
                    end
                    rdCnt0++;
                    if (rdCnt0 == N) begin
                        rdCnt0   = 0;
                        fallArm0 = 1'b1;
                        endLog.push_back(cyc);
                    end
                end

                if (m1If.rd_data_valid) begin
                    if (expRd1.size() == 0) begin
                        checkOutput("m1RdUnexpected", m1If.rd_data, 0);
                    end else begin
                        d = expRd1.pop_front();
                        checkOutput("m1RdData", m1If.rd_data, d);
                    end
                    rdCnt1++;
                    if (rdCnt1 == N) begin
                        rdCnt1   = 0;
                        fallArm1 = 1'b1;
                        endLog.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int i0;
        int e0;
        int s0;
        int dropCyc;
        int beats;
        int k;

        m0If.cmd = 1'b0; m0If.cmd_en = 1'b0; m0If.addr = '0; m0If.data_mask = '0;
        m1If.cmd = 1'b0; m1If.cmd_en = 1'b0; m1If.addr = '0; m1If.data_mask = '0;
        for (int i = 0; i < N; i++) begin
            wrBuf0[i] = '0;
            wrBuf1[i] = '0;
        end

        // Reset state.
        @(negedge clk);
        checkOutput("rstCmdEn", brIf.cmd_en, 0);
        checkOutput("rstCmd", brIf.cmd, 0);
        checkOutput("rstAddr", brIf.addr, 0);
        checkOutput("rstBusy", {m1If.busy, m0If.busy}, 0);
        startCycle();
        startCycle();
        rst = 1'b0;

        // Simultaneous requests straight after reset: port 0 wins, port 1
        // follows without an extra idle cycle.
        startCycle();
        i0 = issueLog.size();
        e0 = endLog.size();
        applyStimulus(0, 1'b0, 8'h01, '0, '0, 1'b1);
        applyStimulus(1, 1'b0, 8'h02, '0, '0, 1'b1);
        startCycle();
        releaseEnables();
        waitIdle();
        checkOutput("b2bGap", (issueLog.size() > i0 + 1 && endLog.size() > e0) ?
                    64'(issueLog[i0 + 1] - endLog[e0]) : 64'hFFFF, 2);

        // Single read from port 0.
        startCycle();
        applyStimulus(0, 1'b0, 8'h12, '0, '0, 1'b1);
        startCycle();
        releaseEnables();
        waitIdle();

        // Tie after port 0 won last: port 1 goes first.
        startCycle();
        applyStimulus(1, 1'b0, 8'h21, '0, '0, 1'b1);
        applyStimulus(0, 1'b0, 8'h20, '0, '0, 1'b1);
        startCycle();
        releaseEnables();
        waitIdle();

        // Writes from both ports.
        startCycle();
        applyStimulus(1, 1'b1, 8'h40, 64'hA, 8'h5A, 1'b1);
        startCycle();
        releaseEnables();
        waitIdle();
        startCycle();
        applyStimulus(0, 1'b1, 8'h41, 64'h1111_2222_0000_0000, 8'hF0, 1'b1);
        startCycle();
        releaseEnables();
        waitIdle();

        // RAM busy holds off the issue until the cycle after it drops.
        startCycle();
        brBusy = 1'b1;
        s0 = issueLog.size();
        applyStimulus(0, 1'b0, 8'h33, '0, '0, 1'b1);
        startCycle();
        releaseEnables();
        repeat (4) startCycle();
        checkOutput("busyHold", 64'(issueLog.size() - s0), 0);
        brBusy  = 1'b0;
        dropCyc = cyc;
        waitIdle();
        checkOutput("busyRelease", (issueLog.size() > s0) ? 64'(issueLog[s0] - dropCyc) : 64'hFFFF, 1);

        // A repeat pulse from the busy owner is dropped; the other port's
        // request is held and served right after.
        startCycle();
        s0 = issueLog.size();
        e0 = endLog.size();
        applyStimulus(0, 1'b0, 8'h60, '0, '0, 1'b1);
        startCycle();
        releaseEnables();
        repeat (3) startCycle();
        applyStimulus(0, 1'b0, 8'h77, '0, '0, 1'b0);
        applyStimulus(1, 1'b0, 8'h61, '0, '0, 1'b1);
        startCycle();
        releaseEnables();
        waitIdle();
        repeat (6) @(negedge clk);
        checkOutput("ignoredReq", 64'(issueLog.size() - s0), 2);
        checkOutput("heldGap", (issueLog.size() > s0 + 1 && endLog.size() > e0) ?
                    64'(issueLog[s0 + 1] - endLog[e0]) : 64'hFFFF, 2);

        // Reset during the second read beat.
        startCycle();
        s0 = issueLog.size();
        applyStimulus(0, 1'b0, 8'h55, '0, '0, 1'b1);
        startCycle();
        releaseEnables();
        beats = 0;
        k = 0;
        while (beats < 2 && k < 100) begin
            @(negedge clk);
            if (m0If.rd_data_valid) beats++;
            k++;
        end
        if (beats < 2) checkOutput("beatTimeout", 64'(beats), 2);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midRstBusy", {m1If.busy, m0If.busy}, 0);
        checkOutput("midRstValid", {m1If.rd_data_valid, m0If.rd_data_valid}, 0);
        checkOutput("midRstCmdEn", brIf.cmd_en, 0);
        checkOutput("midRstWrBeat", {m1If.wr_beat, m0If.wr_beat}, 0);
        startCycle();
        startCycle();
        rst = 1'b0;
        strayValid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("strayFwd", {m1If.rd_data_valid, m0If.rd_data_valid}, 0);
            checkOutput("strayBusy", {m1If.busy, m0If.busy}, 0);
        end
        startCycle();
        strayValid = 1'b0;
        repeat (3) startCycle();
        checkOutput("noReissue", 64'(issueLog.size() - s0), 1);

        // Tie after reset: port 0 wins again.
        startCycle();
        applyStimulus(0, 1'b0, 8'h70, '0, '0, 1'b1);
        applyStimulus(1, 1'b0, 8'h71, '0, '0, 1'b1);
        startCycle();
        releaseEnables();
        waitIdle();

        checkOutput("leftover", 64'(expIssue.size() + expRd0.size() + expRd1.size() + expWr.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/burst_ram_arbiter.md
BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

Interface
REQ-001 SHALL have parameter RAM_DEPTH_BITWIDTH, default 8: burst address width.
REQ-002 SHALL have parameter RAM_BURST_DATA_BITWIDTH, default 64: beat width; mask is RAM_BURST_DATA_BITWIDTH/8 bits.
REQ-003 SHALL have parameter RAM_BURST_DATA_COUNT, default 4: beats per burst, a power of two and at least 2.
REQ-004 SHALL have ports `clk` (in, 1, the single clock) and `rst` (in, 1, reset).
- `rst` is asynchronous and active-high.
REQ-005 SHALL have, for each requester N in {0,1}, the following ports (mirroring the BurstRAM wiring):
- mN_cmd (in, 1): 0 = read, 1 = write.
- mN_cmd_en (in, 1): one-cycle request pulse.
- mN_addr (in, RAM_DEPTH_BITWIDTH): burst address.
- mN_wr_data (in, beat width): write beat.
- mN_data_mask (in, mask width): write byte mask.
- mN_rd_data (out, beat width): read beat.
- mN_rd_data_valid (out, 1): read beat valid.
- mN_busy (out, 1): request pending or in flight.
- mN_wr_beat (out, 1): the current mN_wr_data/mask is consumed this cycle.
REQ-006 SHALL have RAM-side ports br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask (out) and br_rd_data, br_rd_data_valid, br_busy (in), with widths as in REQ-005.

Function
REQ-007 SHALL latch a request into per-port pending slot N (cmd, addr) when mN_cmd_en=1 and mN_busy=0.
- mN_cmd_en while mN_busy=1 SHALL be ignored.
REQ-008 SHALL drive mN_busy combinationally as pending[N] OR (state!=IDLE AND owner==N).
REQ-009 SHALL implement states IDLE, ISSUE, READ, WRITE.
REQ-010 IDLE -> ISSUE when any pending slot is set and br_busy=0.
- owner := selected port.
- The selected pending slot clears.
REQ-011 Arbitration SHALL be round-robin:
- If only one slot is pending, that port is granted.
- If both are pending, the port not granted last is granted.
- last_grant updates at each grant.
REQ-012 ISSUE SHALL last one cycle.
- Registered outputs: br_cmd_en=1, br_cmd/br_addr from owner's latched request.
- br_cmd_en SHALL be 0 in every other state.
REQ-013 ISSUE -> READ if owner cmd=0; ISSUE -> WRITE if cmd=1.
REQ-014 READ SHALL count br_rd_data_valid beats.
- On beat RAM_BURST_DATA_COUNT it SHALL return to IDLE in the next cycle.
- The counter resets to 0.
REQ-015 Write beats SHALL be timed as follows:
- Beat 0 is the ISSUE cycle.
- WRITE lasts RAM_BURST_DATA_COUNT-1 cycles, then goes to IDLE.
- mN_wr_beat=1 for owner N in ISSUE(write) and WRITE cycles, else 0.
REQ-016 br_wr_data/br_data_mask SHALL be combinationally muxed from the owner's mN_wr_data/mN_data_mask.
- They are zero when not in ISSUE(write)/WRITE.
REQ-017 mN_rd_data SHALL equal br_rd_data for both ports.
- mN_rd_data_valid = br_rd_data_valid AND state==READ AND owner==N.
REQ-018 br_rd_data_valid outside READ SHALL be ignored: no counting, no forwarding.
REQ-019 A request from the owning port is impossible while it is busy; a request from the other port during a transaction SHALL be latched and served next.
REQ-020 Back-to-back: IDLE with a pending slot and br_busy=0 SHALL issue in the cycle following the return to IDLE; no extra idle cycles.
REQ-021 Beat counter width SHALL be $clog2(RAM_BURST_DATA_COUNT)+1 bits, with no wrap inside a burst.

Reset
REQ-022 While `rst`=1, asynchronously, the block SHALL clear:
- state=IDLE
- pending slots, owner=0, last_grant=1 (port 0 wins first tie)
- beat counter
- br_cmd_en=0, br_cmd=0, br_addr=0
REQ-023 Reset mid-transaction SHALL drop all in-flight and pending requests without completion.
- After reset, mN_busy=0 and all valid/beat strobes are 0.

Verification
REQ-024 Port 0 read at addr 0x12, br_busy=0 ->
- br_cmd_en high exactly 1 cycle, br_addr=0x12, br_cmd=0.
- 4 valid beats appear only on m0_rd_data_valid.
- m0_busy falls 1 cycle after beat 4.
REQ-025 m0 read 0x01 and m1 read 0x02 pulsed in the same cycle after reset -> 0x01 issued first, 0x02 issued the cycle after the first burst returns to IDLE.
REQ-026 m1 write 0x40, data 0xA..D over 4 beats ->
- m1_wr_beat high 4 consecutive cycles starting at br_cmd_en.
- br_wr_data sequence A,B,C,D; mask passed through.
REQ-027 br_busy=1 held 5 cycles with m0 pending -> no br_cmd_en until the cycle after br_busy falls.
REQ-028 rst asserted during READ beat 2 -> immediately IDLE, busies 0; a stray br_rd_data_valid after reset is not forwarded.
REQ-029 m0_cmd_en pulsed while m0_busy=1 -> ignored: no second burst issued.
